// File: rtl/ula_op_sequencer_pkg.sv
// Shared definitions for the ULA op sequencer: opcodes, FSM states, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ula_op_sequencer_pkg;

  localparam int ULA_WIDTH   = 8;
  localparam int ULA_NUM_OPS = 8;

  // Opcode n drives EN line n of the function units.
  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_NOT = 4'd2,
    OP_XOR = 4'd3,
    OP_ADD = 4'd4,
    OP_SUB = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/ula_op_sequencer_if.sv
// Bundles the sequencer's command, unit-side and result handshake signals.
// Latency: n/a (wires only).
// Backpressure: in_ready/res_ready carry the valid/ready flow control.
// Ports: command (in_valid/in_ready/op/a/b), unit side (opnd_a/opnd_b/en/bus_in),
//        result (res_valid/res_ready/res/flag_z/flag_c/flag_n/err_op).
// master = environment (source, units, consumer); slave = the sequencer.
interface ula_op_sequencer_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   opnd_a;
  logic [WIDTH-1:0]   opnd_b;
  logic [NUM_OPS-1:0] en;
  logic [WIDTH:0]     bus_in;
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH:0]     res;
  logic               flag_z;
  logic               flag_c;
  logic               flag_n;
  logic               err_op;

  modport master (
    output in_valid, op, a, b, bus_in, res_ready,
    input  in_ready, opnd_a, opnd_b, en, res_valid, res, flag_z, flag_c, flag_n, err_op
  );

  modport slave (
    input  in_valid, op, a, b, bus_in, res_ready,
    output in_ready, opnd_a, opnd_b, en, res_valid, res, flag_z, flag_c, flag_n, err_op
  );
endinterface

// File: rtl/ula_op_sequencer_decoder.sv
// Opcode to one-hot unit-enable decoder (module ula_op_decoder).
// Latency: combinational; the sequencer registers the result into en.
// Backpressure: none.
// Ports: op (in), onehot (out, NUM_OPS), op_valid (out, op < NUM_OPS).
module ula_op_decoder #(
  parameter int NUM_OPS = 8
) (
  input  logic [3:0]         op,
  output logic [NUM_OPS-1:0] onehot,
  output logic               op_valid
);
  always_comb begin
    op_valid = (32'(op) < NUM_OPS);
    onehot   = op_valid ? (NUM_OPS'(1) << op) : '0;
  end
endmodule

// File: rtl/ula_op_sequencer.sv
// Sequences one ULA op: registers operands, enables exactly one unit, captures the bus.
// Latency: accept to res_valid = SETTLE_CYCLES+1 edges (1 edge for an invalid opcode).
// Backpressure: in_ready low while driving or while a held result is not taken.
// Ports: clk, rst_n (async active-low), io (slave side of ula_op_sequencer_if).
module ula_op_sequencer
  import ula_op_sequencer_pkg::*;
#(
  parameter int WIDTH         = ULA_WIDTH,
  parameter int NUM_OPS       = ULA_NUM_OPS,
  parameter int SETTLE_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  ula_op_sequencer_if.slave io
);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_OPS-1:0] dec_onehot;
  logic               dec_valid;
  logic               accept;

  logic [WIDTH-1:0]   opnd_a_q, opnd_b_q;
  logic [NUM_OPS-1:0] en_q;
  logic [WIDTH:0]     res_q;
  logic               res_valid_q, flag_z_q, flag_c_q, flag_n_q, err_op_q;

  ula_op_decoder #(.NUM_OPS(NUM_OPS)) u_dec (
    .op       (io.op),
    .onehot   (dec_onehot),
    .op_valid (dec_valid)
  );

  // Gated by rst_n so the source sees not-ready for the whole reset window.
  assign io.in_ready = rst_n & ((state == ST_IDLE) | ((state == ST_HOLD) & io.res_ready));
  assign accept      = io.in_valid & io.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      opnd_a_q    <= '0;
      opnd_b_q    <= '0;
      en_q        <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      err_op_q    <= 1'b0;
    end else if (accept) begin
      // Accept has priority so a HOLD handoff takes the next op with no bubble.
      opnd_a_q <= io.a;
      opnd_b_q <= io.b;
      if (dec_valid) begin
        state       <= ST_DRIVE;
        en_q        <= dec_onehot;
        cnt         <= CNT_LOAD;
        res_valid_q <= 1'b0;
      end else begin
        // Invalid opcode: no unit is enabled; report a zero result with err_op.
        state       <= ST_HOLD;
        en_q        <= '0;
        res_q       <= '0;
        flag_z_q    <= 1'b1;
        flag_c_q    <= 1'b0;
        flag_n_q    <= 1'b0;
        err_op_q    <= 1'b1;
        res_valid_q <= 1'b1;
      end
    end else begin
      case (state)
        ST_DRIVE: begin
          if (cnt == '0) begin
            res_q       <= io.bus_in;
            flag_z_q    <= ~|io.bus_in[WIDTH-1:0];
            flag_c_q    <= io.bus_in[WIDTH];
            flag_n_q    <= io.bus_in[WIDTH-1];
            err_op_q    <= 1'b0;
            en_q        <= '0;
            res_valid_q <= 1'b1;
            state       <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (io.res_ready) begin
            state       <= ST_IDLE;
            res_valid_q <= 1'b0;
          end
        end
        ST_IDLE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io.opnd_a    = opnd_a_q;
  assign io.opnd_b    = opnd_b_q;
  assign io.en        = en_q;
  assign io.res       = res_q;
  assign io.res_valid = res_valid_q;
  assign io.flag_z    = flag_z_q;
  assign io.flag_c    = flag_c_q;
  assign io.flag_n    = flag_n_q;
  assign io.err_op    = err_op_q;
endmodule

// File: tb/tb_ula_op_sequencer.sv
// Testbench for ula_op_sequencer: directed literal cases plus random traffic
// checked every cycle against a transaction-level model of the sequencer.
module tb_ula_op_sequencer;
  localparam int W  = 8;
  localparam int NO = 8;
  localparam int SETTLE = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W:0] junk = 9'h0A5;

  int n_chk = 0;
  int n_pass = 0;

  ula_op_sequencer_if #(.WIDTH(W), .NUM_OPS(NO)) ifc ();

  ula_op_sequencer #(.WIDTH(W), .NUM_OPS(NO), .SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ifc)
  );

  always #5 clk = ~clk;

  // Function unit behaviour (what each enabled unit puts on the shared bus).
  function automatic logic [W:0] unit_f(int op, logic [W-1:0] x, logic [W-1:0] y);
    case (op)
      0: return {1'b0, x & y};
      1: return {1'b0, x | y};
      2: return {1'b0, ~x};
      3: return {1'b0, x ^ y};
      4: return {1'b0, x} + {1'b0, y};
      5: return {1'b0, x} - {1'b0, y};
      6: return {x, 1'b0};
      7: return {x[0], 1'b0, x[W-1:1]};
      default: return '0;
    endcase
  endfunction

  // Tri-state bus emulation: the single enabled unit drives it, otherwise garbage.
  always_comb begin
    ifc.bus_in = junk;
    for (int i = 0; i < NO; i++)
      if (ifc.en == (NO'(1) << i)) ifc.bus_in = unit_f(i, ifc.opnd_a, ifc.opnd_b);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- transaction-level model ----------------
  int              drive_left = 0;   // cycles an accepted op still has its unit enabled
  int              pend_op = 0;
  logic [W-1:0]    pend_a = '0, pend_b = '0;
  logic [NO-1:0]   m_en = '0;
  logic            m_rv = 1'b0;
  logic [W:0]      m_res = '0;
  logic            m_err = 1'b0;
  logic [W-1:0]    m_opa = '0, m_opb = '0;

  always @(negedge clk) begin
    logic m_rdy;
    logic acc;
    if (!rst_n) begin
      drive_left = 0; m_en = '0; m_rv = 1'b0; m_res = '0; m_err = 1'b0;
      m_opa = '0; m_opb = '0;
    end else begin
      m_rdy = (drive_left == 0) && (!m_rv || ifc.res_ready);
      chk("m_in_ready", ifc.in_ready, m_rdy);
      chk("m_en", ifc.en, m_en);
      chk("m_res_valid", ifc.res_valid, m_rv);
      chk("m_opnd_a", ifc.opnd_a, m_opa);
      chk("m_opnd_b", ifc.opnd_b, m_opb);
      if (m_rv) begin
        chk("m_res", ifc.res, m_res);
        chk("m_flag_z", ifc.flag_z, m_res[W-1:0] == 0);
        chk("m_flag_c", ifc.flag_c, m_res[W]);
        chk("m_flag_n", ifc.flag_n, m_res[W-1]);
        chk("m_err_op", ifc.err_op, m_err);
      end
      // Advance the model to what must hold after the coming edge.
      acc = ifc.in_valid && m_rdy;
      if (m_rv && ifc.res_ready) m_rv = 1'b0;
      if (drive_left > 0) begin
        drive_left--;
        if (drive_left == 0) begin
          m_res = unit_f(pend_op, pend_a, pend_b);
          m_err = 1'b0; m_rv = 1'b1; m_en = '0;
        end
      end
      if (acc) begin
        m_opa = ifc.a; m_opb = ifc.b;
        if (int'(ifc.op) < NO) begin
          drive_left = SETTLE; pend_op = int'(ifc.op);
          pend_a = ifc.a; pend_b = ifc.b;
          m_en = NO'(1) << ifc.op;
        end else begin
          m_rv = 1'b1; m_res = '0; m_err = 1'b1;
        end
      end
    end
  end

  task automatic present(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic rr);
    ifc.in_valid = 1'b1; ifc.op = op; ifc.a = a; ifc.b = b; ifc.res_ready = rr;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    logic fired;
    ifc.in_valid = 1'b0; ifc.op = '0; ifc.a = '0; ifc.b = '0; ifc.res_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", ifc.in_ready, 0);
    chk("rst_en", ifc.en, 0);
    chk("rst_res_valid", ifc.res_valid, 0);
    chk("rst_res", ifc.res, 0);
    chk("rst_flags_err", {ifc.flag_z, ifc.flag_c, ifc.flag_n, ifc.err_op}, 0);
    chk("rst_opnd", {ifc.opnd_a, ifc.opnd_b}, 0);
    #1 rst_n = 1'b1;

    // OR 0x0F | 0xF0, then 5 cycles of backpressure
    tick(); present(4'd1, 8'h0F, 8'hF0, 1'b0);
    @(negedge clk); chk("or_in_ready", ifc.in_ready, 1);
    tick(); ifc.in_valid = 1'b0;
    @(negedge clk); chk("or_en", ifc.en, 8'b0000_0010); chk("or_rv_early", ifc.res_valid, 0);
    tick();
    @(negedge clk);
    chk("or_en_off", ifc.en, 0); chk("or_rv", ifc.res_valid, 1); chk("or_res", ifc.res, 9'h0FF);
    chk("or_zcne", {ifc.flag_z, ifc.flag_c, ifc.flag_n, ifc.err_op}, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      tick(); @(negedge clk);
      chk("bp_res", ifc.res, 9'h0FF); chk("bp_in_ready", ifc.in_ready, 0);
      chk("bp_en", ifc.en, 0); chk("bp_rv", ifc.res_valid, 1);
    end
    tick(); ifc.res_ready = 1'b1;
    @(negedge clk); chk("bp_release_rdy", ifc.in_ready, 1);
    tick(); @(negedge clk); chk("bp_idle_rv", ifc.res_valid, 0);

    // ADD 0xFF + 0x01
    tick(); present(4'd4, 8'hFF, 8'h01, 1'b1);
    tick(); ifc.in_valid = 1'b0;
    @(negedge clk); chk("add_en", ifc.en, 8'b0001_0000);
    tick(); @(negedge clk);
    chk("add_res", ifc.res, 9'h100);
    chk("add_zcne", {ifc.flag_z, ifc.flag_c, ifc.flag_n, ifc.err_op}, 4'b1100);
    tick();

    // Invalid opcode 9
    present(4'd9, 8'h33, 8'h44, 1'b0);
    tick(); ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("inv_en", ifc.en, 0); chk("inv_rv", ifc.res_valid, 1); chk("inv_res", ifc.res, 0);
    chk("inv_zcne", {ifc.flag_z, ifc.flag_c, ifc.flag_n, ifc.err_op}, 4'b1001);

    // Back-to-back: SUB 0x05 - 0x07 accepted straight out of HOLD
    tick(); present(4'd5, 8'h05, 8'h07, 1'b1);
    @(negedge clk); chk("b2b_in_ready", ifc.in_ready, 1);
    tick(); ifc.in_valid = 1'b0;
    @(negedge clk); chk("b2b_en", ifc.en, 8'b0010_0000); chk("b2b_rv", ifc.res_valid, 0);
    tick(); @(negedge clk);
    chk("sub_res", ifc.res, 9'h1FE); chk("sub_rv", ifc.res_valid, 1);
    chk("sub_zcne", {ifc.flag_z, ifc.flag_c, ifc.flag_n, ifc.err_op}, 4'b0110);
    tick();

    // Reset in the middle of DRIVE
    present(4'd4, 8'h10, 8'h20, 1'b1);
    tick(); ifc.in_valid = 1'b0;
    chk("mid_en_on", ifc.en, 8'b0001_0000);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_en_async", ifc.en, 0); chk("mid_in_ready", ifc.in_ready, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); chk("post_rst_rdy", ifc.in_ready, 1); chk("post_rst_rv", ifc.res_valid, 0);
    tick(); @(negedge clk); chk("post_rst_rv2", ifc.res_valid, 0);

    // Random traffic, source holds its inputs until accepted
    ifc.res_ready = 1'b1;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk); fired = ifc.in_valid & ifc.in_ready;
      @(posedge clk); #1;
      if (!ifc.in_valid || fired) begin
        ifc.in_valid = ($urandom_range(0, 3) != 0);
        ifc.op = 4'($urandom_range(0, 11));
        ifc.a = 8'($urandom); ifc.b = 8'($urandom);
      end
      ifc.res_ready = ($urandom_range(0, 2) != 0);
      junk = 9'($urandom);
    end
    ifc.in_valid = 1'b0; ifc.res_ready = 1'b1;
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
